booth_1_mult: RTL and testbench

Sequential radix-2 Booth multiplier for signed two's-complement operands. It loads a 32-bit multiplicand and multiplier, performs one Booth recoding step per enabled clock, and presents the 64-bit signed product on a registered output. It serves as a low-area multiplier datapath block driven by a controller that issues a load pulse and then waits a fixed number of cycles.

---
 rtl/booth_pkg.sv | 10 +
 rtl/booth_step.sv | 22 ++
 rtl/booth_1_mult.sv | 60 ++++++
 tb/tb_booth_1_mult.sv | 97 +++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, state encoding and counter sizing for the radix-2 Booth multiplier
package booth_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int STEPS = DEF_WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
    localparam int CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth recode, add/subtract and arithmetic right shift of {acc, q, q1}
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_n,
    output logic [WIDTH-1:0] q_n,
    output logic             q1_n
);
    logic [WIDTH:0] sum;
    always_comb begin
        sum = (q[0] & ~q1) ? acc - m : (~q[0] & q1) ? acc + m : acc;
        acc_n = {sum[WIDTH], sum[WIDTH:1]};
        q_n = {sum[0], q[WIDTH-1:1]};
        q1_n = q[0];
    end
endmodule

// File: rtl/booth_1_mult.sv
// booth_1_mult: sequential radix-2 Booth multiplier, WIDTH steps then one output-register edge
module booth_1_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] OUT
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] acc, m, acc_n;
    logic [WIDTH-1:0] q, q_n;
    logic q1, q1_n;
    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc(acc), .q(q), .q1(q1), .m(m),
        .acc_n(acc_n), .q_n(q_n), .q1_n(q1_n)
    );
    always_comb begin
        state_n = state;
        if (en)
            state_n = load ? RUN : (state == RUN && cnt == CW'(WIDTH - 1)) ? DONE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            m <= '0;
            q <= '0;
            q1 <= 1'b0;
            OUT <= '0;
        end else begin
            state <= state_n;
            if (en) begin
                if (load) begin
                    // ACC is one bit wider so -M of the most negative A cannot overflow
                    m <= {A[WIDTH-1], A};
                    q <= B;
                    acc <= '0;
                    q1 <= 1'b0;
                    cnt <= '0;
                end else if (state == RUN) begin
                    acc <= acc_n;
                    q <= q_n;
                    q1 <= q1_n;
                    cnt <= cnt + 1'b1;
                end else if (state == DONE) begin
                    OUT <= {acc[WIDTH-1:0], q};
                end
            end
        end
    end
endmodule

// File: tb/tb_booth_1_mult.sv
// tb_booth_1_mult: directed vectors with hand-computed products, plus enable, reset and reload control cases
module tb_booth_1_mult;
    logic clk = 1'b0;
    logic rst, en, load;
    logic [31:0] a, b;
    logic [63:0] out;
    logic [63:0] prev;
    int n_cmp = 0;
    int n_bad = 0;
    booth_1_mult dut (.clk(clk), .rst(rst), .en(en), .load(load), .A(a), .B(b), .OUT(out));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic start(input logic [31:0] x, input logic [31:0] y, input int edges);
        a = x;
        b = y;
        load = 1'b1;
        step(edges);
        load = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask
    task automatic mult(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
        start(x, y, 2);
        step(32);
        check({tag, "_pre"}, out, prev);
        step(1);
        check(tag, out, exp);
        prev = exp;
    endtask
    initial begin
        rst = 1'b1;
        en = 1'b1;
        load = 1'b0;
        a = '0;
        b = '0;
        prev = '0;
        step(2);
        check("reset", out, 64'h0);
        rst = 1'b0;
        step(1);
        mult("pos_small", 32'h00087234, 32'h00000348, 64'h000000001BB6BAA0);
        step(5);
        check("done_hold", out, 64'h000000001BB6BAA0);
        mult("mixed", 32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564);
        mult("mixed_swap", 32'hFFFFFEFD, 32'h00087234, 64'hFFFFFFFFF7747564);
        mult("neg_neg", 32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609);
        mult("large_nn", 32'hB887CAAF, 32'h887CAAF3, 64'h215D8B0A7A419A1D);
        mult("large_pn", 32'h50647236, 32'hB887CAAF, 64'hE98E647F4142AEEA);
        mult("one_x", 32'h00000001, 32'h50647236, 64'h0000000050647236);
        mult("x_one", 32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF);
        mult("zero_x", 32'h00000000, 32'hB887CAAF, 64'h0);
        mult("x_zero", 32'h50647236, 32'h00000000, 64'h0);
        mult("min_min", 32'h80000000, 32'h80000000, 64'h4000000000000000);
        mult("min_max", 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000);
        // enable gap: 5 frozen edges push completion back by 5
        start(32'hB887CAAF, 32'h887CAAF3, 1);
        step(10);
        en = 1'b0;
        step(5);
        en = 1'b1;
        step(18);
        check("en_gap_pre", out, prev);
        step(4);
        check("en_gap_pre2", out, prev);
        step(1);
        check("en_gap", out, 64'h215D8B0A7A419A1D);
        prev = 64'h215D8B0A7A419A1D;
        // reload mid-run restarts the 33-edge latency for the new operands
        start(32'h00087234, 32'h00000348, 1);
        step(10);
        start(32'h50647236, 32'hB887CAAF, 1);
        step(32);
        check("reload_pre", out, prev);
        step(1);
        check("reload", out, 64'hE98E647F4142AEEA);
        // async reset mid-run clears OUT before the next clock edge
        start(32'h00087234, 32'hFFFFFEFD, 1);
        step(10);
        #1 rst = 1'b1;
        #1 check("rst_async", out, 64'h0);
        step(1);
        rst = 1'b0;
        prev = '0;
        mult("after_rst", 32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
